// File: rtl/ram_multiport_pkg.sv
// Shared types and constants for the multi-port RAM: init FSM states,
// read-during-write policy codes and the lane-count helper.
package ram_multiport_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } ram_init_state_t;

  localparam bit RDW_OLD = 1'b0;
  localparam bit RDW_NEW = 1'b1;

  function automatic int lane_count(input int dwidth, input int lane_w);
    return dwidth / lane_w;
  endfunction

endpackage

// File: rtl/ram_multiport_if.sv
// Bus bundle for ram_multiport: masked write port, RD_PORTS read ports, init status.
interface ram_multiport_if #(
  parameter int AWIDTH   = 4,
  parameter int DWIDTH   = 8,
  parameter int NLANES   = 2,
  parameter int RD_PORTS = 2
);

  logic                         init_busy;
  logic                         wr_en;
  logic [AWIDTH-1:0]            wr_addr;
  logic [DWIDTH-1:0]            wr_data;
  logic [NLANES-1:0]            wr_mask;
  logic [RD_PORTS-1:0]          rd_en;
  logic [RD_PORTS*AWIDTH-1:0]   rd_addr;
  logic [RD_PORTS*DWIDTH-1:0]   rd_data;
  logic [RD_PORTS-1:0]          rd_valid;

  modport master (
    input  init_busy, rd_data, rd_valid,
    output wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr
  );

  modport slave (
    output init_busy, rd_data, rd_valid,
    input  wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr
  );

endinterface

// File: rtl/ram_multiport_rdport.sv
// One read port: address decode, optional same-cycle write bypass, optional output register.
module ram_multiport_rdport
  import ram_multiport_pkg::*;
#(
  parameter int AWIDTH     = 4,
  parameter int DWIDTH     = 8,
  parameter int RD_LAT     = 0,
  parameter bit BYPASS_NEW = RDW_OLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_busy,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic [DWIDTH-1:0] mem [2**AWIDTH],
  input  logic              wr_hit,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_word,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid
);

  logic [DWIDTH-1:0] rd_word;
  assign rd_word = mem[rd_addr];

  if (RD_LAT == 0) begin : g_comb
    // Combinational read never sees the write that lands on this edge.
    logic unused_lat0;
    assign unused_lat0 = ^{clk, rst, wr_hit, wr_addr, wr_word};
    assign rd_data     = rd_word;
    assign rd_valid    = rd_en & ~init_busy;
  end else begin : g_reg
    logic [DWIDTH-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              bypass;

    always_comb begin
      bypass     = (BYPASS_NEW == RDW_NEW) && wr_hit && (wr_addr == rd_addr);
      rd_valid_d = rd_en & ~init_busy;
      rd_data_d  = rd_data_q;
      if (rd_valid_d) rd_data_d = bypass ? wr_word : rd_word;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: rtl/ram_multiport.sv
// Multi-port RAM: one lane-masked write port, RD_PORTS read ports, and a
// post-reset init engine that fills every word before the array is usable.
module ram_multiport
  import ram_multiport_pkg::ram_init_state_t, ram_multiport_pkg::ST_INIT,
         ram_multiport_pkg::ST_READY, ram_multiport_pkg::lane_count;
#(
  parameter int AWIDTH   = 4,
  parameter int DWIDTH   = 8,
  parameter int LANE_W   = 4,
  parameter int RD_PORTS = 2,
  parameter int RD_LAT   = 0,
  parameter bit RDW_NEW  = 1'b0,
  parameter int INIT_PAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  ram_multiport_if.slave bus
);

  localparam int NLANES = lane_count(DWIDTH, LANE_W);
  localparam int DEPTH  = 2**AWIDTH;

  if (DWIDTH % LANE_W != 0) begin : g_bad_lane
    $error("ram_multiport: DWIDTH must be a multiple of LANE_W");
  end

  ram_init_state_t   state_q, state_d;
  logic [AWIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              wr_hit;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = bus.wr_addr;
    mem_wdata  = mem_q[bus.wr_addr];
    wr_hit     = 1'b0;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) state_d = ST_READY;
      mem_we    = 1'b1;
      mem_waddr = init_cnt_q;
      mem_wdata = (INIT_PAT != 0) ? DWIDTH'(init_cnt_q) : '0;
    end else if (bus.wr_en) begin
      wr_hit = 1'b1;
      mem_we = |bus.wr_mask;
      for (int k = 0; k < NLANES; k++) begin
        if (bus.wr_mask[k]) mem_wdata[k*LANE_W +: LANE_W] = bus.wr_data[k*LANE_W +: LANE_W];
      end
    end
  end

  // NOTE: the storage array has no reset; the init engine gives it defined content instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.init_busy = (state_q == ST_INIT);

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    ram_multiport_rdport #(
      .AWIDTH     (AWIDTH),
      .DWIDTH     (DWIDTH),
      .RD_LAT     (RD_LAT),
      .BYPASS_NEW (RDW_NEW)
    ) u_rdport (
      .clk       (clk),
      .rst       (rst),
      .init_busy (bus.init_busy),
      .rd_en     (bus.rd_en[p]),
      .rd_addr   (bus.rd_addr[p*AWIDTH +: AWIDTH]),
      .mem       (mem_q),
      .wr_hit    (wr_hit),
      .wr_addr   (bus.wr_addr),
      .wr_word   (mem_wdata),
      .rd_data   (bus.rd_data[p*DWIDTH +: DWIDTH]),
      .rd_valid  (bus.rd_valid[p])
    );
  end

endmodule

// File: tb/tb_ram_multiport.sv
// Directed bench for ram_multiport: four configurations driven in lock-step,
// expectations queued as stimulus is applied and compared when outputs appear.
module tb_ram_multiport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_multiport_if #(.AWIDTH(4), .DWIDTH(8), .NLANES(2), .RD_PORTS(2)) a_if ();
  ram_multiport_if #(.AWIDTH(4), .DWIDTH(8), .NLANES(2), .RD_PORTS(2)) b_if ();
  ram_multiport_if #(.AWIDTH(4), .DWIDTH(8), .NLANES(2), .RD_PORTS(2)) c_if ();
  ram_multiport_if #(.AWIDTH(3), .DWIDTH(4), .NLANES(1), .RD_PORTS(1)) d_if ();

  // Combinational read, default parameters.
  ram_multiport #(.RD_LAT(0)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  // Registered read, new-data and old-data read-during-write; c mirrors b's stimulus.
  ram_multiport #(.RD_LAT(1), .RDW_NEW(1'b1)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  ram_multiport #(.RD_LAT(1), .RDW_NEW(1'b0)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));
  // Small zero-initialised array.
  ram_multiport #(.AWIDTH(3), .DWIDTH(4), .LANE_W(4), .RD_PORTS(1), .RD_LAT(0), .INIT_PAT(0))
    u_d (.clk(clk), .rst(rst), .bus(d_if.slave));

  assign c_if.wr_en   = b_if.wr_en;
  assign c_if.wr_addr = b_if.wr_addr;
  assign c_if.wr_data = b_if.wr_data;
  assign c_if.wr_mask = b_if.wr_mask;
  assign c_if.rd_en   = b_if.rd_en;
  assign c_if.rd_addr = b_if.rd_addr;

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic       chk_data;
    logic [1:0] valid;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [7:0] data, input logic chk_data,
                         input logic [1:0] valid);
    exp_t e;
    e.tag = tag; e.data = data; e.chk_data = chk_data; e.valid = valid;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [7:0] obs_data, input logic [1:0] obs_valid);
    exp_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty: observed data=%h valid=%b with no expectation queued",
               obs_data, obs_valid);
    end else begin
      e = sb_q.pop_front();
      assert ((!e.chk_data || obs_data === e.data) && obs_valid === e.valid) else begin
        miscompares++;
        $error("FAIL %s: observed data=%h valid=%b expected data=%h valid=%b",
               e.tag, obs_data, obs_valid, e.data, e.valid);
      end
    end
  endtask

  initial begin
    int cnt;
    int d_cnt;

    a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_data = '0; a_if.wr_mask = '0;
    a_if.rd_en = 2'b11; a_if.rd_addr = '0;
    b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0; b_if.wr_mask = '0;
    b_if.rd_en = 2'b11; b_if.rd_addr = '0;
    d_if.wr_en = 1'b0; d_if.wr_addr = '0; d_if.wr_data = '0; d_if.wr_mask = '0;
    d_if.rd_en = 1'b1; d_if.rd_addr = '0;

    // Reset state: busy, no valid reads, registered outputs cleared.
    tick();
    tick();
    sb_push("rst_a_busy", 8'h01, 1'b1, 2'b00);
    sb_check({7'b0, a_if.init_busy}, a_if.rd_valid);
    sb_push("rst_b_p0_reg", 8'h00, 1'b1, 2'b00);
    sb_check(b_if.rd_data[7:0], b_if.rd_valid);
    sb_push("rst_b_p1_reg", 8'h00, 1'b1, 2'b00);
    sb_check(b_if.rd_data[15:8], b_if.rd_valid);

    // T1/T6: busy length after release (16 for depth 16, 8 for depth 8).
    rst = 1'b0;
    cnt = 0;
    d_cnt = 0;
    sb_push("t1_busy_cycles", 8'd16, 1'b1, 2'b00);
    sb_push("t6_busy_cycles", 8'd8, 1'b1, 2'b00);
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt++;
      if (!d_if.init_busy && d_cnt == 0) d_cnt = cnt;
      if (!a_if.init_busy) break;
    end
    sb_check(8'(cnt), 2'b00);
    sb_check(8'(d_cnt), 2'b00);

    // T6: zero-initialised array reads 0 everywhere.
    for (int i = 0; i < 8; i++) begin
      d_if.rd_addr = 3'(i);
      sb_push($sformatf("t6_addr%0d", i), 8'h00, 1'b1, 2'b01);
      #1;
      sb_check({4'h0, d_if.rd_data}, {1'b0, d_if.rd_valid});
    end
    tick();

    // T1: identity pattern, combinational read.
    a_if.rd_addr = {4'd15, 4'd5};
    sb_push("t1_addr5", 8'h05, 1'b1, 2'b11);
    sb_push("t1_addr15", 8'h0F, 1'b1, 2'b11);
    #1;
    sb_check(a_if.rd_data[7:0], a_if.rd_valid);
    sb_check(a_if.rd_data[15:8], a_if.rd_valid);

    // T2: two masked half-writes to addr 3; same-cycle read sees old data.
    tick();
    a_if.wr_en = 1'b1; a_if.wr_addr = 4'd3; a_if.wr_data = 8'hA5; a_if.wr_mask = 2'b01;
    a_if.rd_addr = {4'd2, 4'd3};
    sb_push("t2_same_cycle_old", 8'h03, 1'b1, 2'b11);
    #1;
    sb_check(a_if.rd_data[7:0], a_if.rd_valid);
    tick();
    a_if.wr_data = 8'h7C; a_if.wr_mask = 2'b10;
    sb_push("t2_after_lane0", 8'h05, 1'b1, 2'b11);
    #1;
    sb_check(a_if.rd_data[7:0], a_if.rd_valid);
    tick();
    a_if.wr_data = 8'hFF; a_if.wr_mask = 2'b00;
    sb_push("t2_after_lane1", 8'h75, 1'b1, 2'b11);
    sb_push("t2_addr2_kept", 8'h02, 1'b1, 2'b11);
    #1;
    sb_check(a_if.rd_data[7:0], a_if.rd_valid);
    sb_check(a_if.rd_data[15:8], a_if.rd_valid);
    tick();
    a_if.wr_en = 1'b0;
    sb_push("t2_mask0_noop", 8'h75, 1'b1, 2'b11);
    #1;
    sb_check(a_if.rd_data[7:0], a_if.rd_valid);

    // T3: registered read during write, new vs old policy.
    b_if.wr_en = 1'b1; b_if.wr_addr = 4'd4; b_if.wr_data = 8'hEE; b_if.wr_mask = 2'b11;
    b_if.rd_en = 2'b01; b_if.rd_addr = {4'd0, 4'd4};
    sb_push("t3_new_full", 8'hEE, 1'b1, 2'b01);
    sb_push("t3_old_full", 8'h04, 1'b1, 2'b01);
    tick();
    sb_check(b_if.rd_data[7:0], b_if.rd_valid);
    sb_check(c_if.rd_data[7:0], c_if.rd_valid);
    b_if.wr_addr = 4'd6; b_if.wr_data = 8'hAB; b_if.wr_mask = 2'b10;
    b_if.rd_addr = {4'd0, 4'd6};
    sb_push("t3_new_partial", 8'hA6, 1'b1, 2'b01);
    sb_push("t3_old_partial", 8'h06, 1'b1, 2'b01);
    tick();
    sb_check(b_if.rd_data[7:0], b_if.rd_valid);
    sb_check(c_if.rd_data[7:0], c_if.rd_valid);
    b_if.wr_en = 1'b0;
    b_if.rd_addr = {4'd0, 4'd4};
    sb_push("t3_new_after", 8'hEE, 1'b1, 2'b01);
    sb_push("t3_old_after", 8'hEE, 1'b1, 2'b01);
    tick();
    sb_check(b_if.rd_data[7:0], b_if.rd_valid);
    sb_check(c_if.rd_data[7:0], c_if.rd_valid);

    // T5: port1 loads addr 9, then is disabled and must hold.
    b_if.rd_en = 2'b11; b_if.rd_addr = {4'd9, 4'd7};
    sb_push("t5_p1_load", 8'h09, 1'b1, 2'b11);
    tick();
    sb_check(b_if.rd_data[15:8], b_if.rd_valid);
    b_if.rd_en = 2'b01; b_if.rd_addr = {4'd7, 4'd7};
    sb_push("t5_p0_addr7", 8'h07, 1'b1, 2'b01);
    sb_push("t5_p1_hold", 8'h09, 1'b1, 2'b01);
    tick();
    sb_check(b_if.rd_data[7:0], b_if.rd_valid);
    sb_check(b_if.rd_data[15:8], b_if.rd_valid);
    b_if.rd_en = 2'b00;

    // T4: reset, run init to count 9, pulse reset, full restart; writes ignored while busy.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    sb_push("t4_busy_at_cnt9", 8'h01, 1'b1, 2'b00);
    sb_check({7'b0, a_if.init_busy}, a_if.rd_valid);
    a_if.wr_en = 1'b1; a_if.wr_addr = 4'd0; a_if.wr_data = 8'hFF; a_if.wr_mask = 2'b11;
    a_if.rd_addr = {4'd0, 4'd0};
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cnt = 0;
    sb_push("t4_busy_cycles", 8'd16, 1'b1, 2'b00);
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt++;
      if (!a_if.init_busy) break;
    end
    sb_check(8'(cnt), 2'b00);
    a_if.wr_en = 1'b0;
    sb_push("t4_addr0_untouched", 8'h00, 1'b1, 2'b11);
    #1;
    sb_check(a_if.rd_data[7:0], a_if.rd_valid);
    sb_push("t4_b_p1_reg_cleared", 8'h00, 1'b1, 2'b00);
    sb_check(b_if.rd_data[15:8], b_if.rd_valid);

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: observed %0d unchecked entries, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
